unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Parametrised arbiter that shares one single-ported memory between the fetch stage and the MEM stage of the pipelined core.
- Replaces the half-rate clock multiplexing scheme with a single-clock design: one memory command per cycle, explicit per-requester grants, stall outputs, and a configurable starvation bound.
- Supports memories with a fixed read latency greater than one, with response routing by in-flight tag.
- Supports fetch flush, so branch redirects can discard stale instruction responses.

Parameters:
- XLEN, 32, data width of memory words and requester data buses.
- ADDR_W, 32, address width.
- MEM_LAT, 1, fixed cycles from read command to m_rdata; legal range 1..8.
- DATA_PRIORITY, 1, 1 = data port wins ties, 0 = fetch port wins ties.
- MAX_STARVE, 4, consecutive denied cycles after which the low-priority requester wins a tie; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- if_req  in  1  fetch read request; held stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  discard all in-flight fetch responses.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  XLEN  fetch read data.
- d_req  in  1  data request; held stable until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  XLEN  write data.
- d_func3  in  3  access size/sign code, forwarded to memory.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data valid.
- d_rdata  out  XLEN  data read data.
- m_en  out  1  memory command valid.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  XLEN  memory write data.
- m_func3  out  3  memory access code; 3'b010 for fetches.
- m_rdata  in  XLEN  memory read data, valid MEM_LAT cycles after a read command.
- stall_if  out  1  if_req & ~if_gnt.
- stall_mem  out  1  d_req & ~d_gnt.

Behaviour:
- Grant logic is combinational from the current requests and the registered starve counter.
  - Only one requester: it is granted.
  - Both requesting: the high-priority port is granted, unless starve_cnt == MAX_STARVE, in which case the low-priority port is granted.
  - Neither requesting: m_en=0, m_we=0, m_addr=0, m_wdata=0, m_func3=0.
- The m_* outputs carry the granted requester's fields in the same cycle. A fetch drives m_we=0 and m_func3=3'b010.
- Starve counter (4 bits) tracks the low-priority port.
  - Increments each cycle that port requests and is denied; saturates at MAX_STARVE.
  - Clears to 0 on that port's grant.
  - Holds when that port is not requesting.
- Tag pipeline: MEM_LAT-stage shift register of 2-bit tags (NONE, IF, D).
  - Stage 0 captures IF for a granted fetch, D for a granted data read, and NONE for a write or idle cycle.
  - When the tag leaves the last stage (cycle t+MEM_LAT for a command in cycle t), m_rdata is routed combinationally to the matching *_rdata and the matching *_rvalid is pulsed for one cycle. The non-matching rdata output holds its last value.
- Writes complete at grant; they produce no rvalid.
- if_flush: in the same cycle, every IF tag in the pipeline, including the one emerging this cycle, is converted to NONE, and if_rvalid is forced to 0.
  - A fetch granted in the same cycle as if_flush is still issued and returns normally.
  - D tags are unaffected.
- Back-to-back issue of one command per cycle is sustained. There is no outstanding-request limit beyond MEM_LAT.
- Reset (rst=0 at a clk edge): all tags become NONE, starve_cnt=0, if_rdata=d_rdata=0.
  - Gnt, rvalid, stall and m_* outputs are 0 while rst=0, regardless of requests.
  - In-flight responses at reset are discarded and never signalled.
- Simultaneous response and new grant to the same port in one cycle is legal and independent.

Test Plan:
1. MEM_LAT=1, DATA_PRIORITY=1: fetch alone at 0x100 in cycle 0 -> if_gnt=1, m_addr=0x100, m_func3=3'b010; next cycle if_rvalid=1 with if_rdata equal to memory word 0x100.
2. Both request every cycle (d read 0x200, fetch 0x104), MAX_STARVE=4 -> d_gnt in cycles 0-3, stall_if=1; cycle 4 if_gnt=1, stall_mem=1; cycle 5 d_gnt again with the counter at 0.
3. MEM_LAT=3: reads granted in cycles 0 (IF), 1 (D read), 2 (D write) -> if_rvalid at cycle 3, d_rvalid at cycle 4, no rvalid at cycle 5.
4. MEM_LAT=3: fetches granted at cycles 0 and 1, if_flush=1 at cycle 2 with a new fetch granted -> no if_rvalid at cycles 3 and 4; if_rvalid at cycle 5.
5. Data write 0xDEADBEEF to 0x40 with d_func3=3'b010, then data read 0x40 -> m_we=1 only in the write cycle; d_rdata=0xDEADBEEF MEM_LAT cycles after the read grant.
6. rst driven low for one cycle while two reads are in flight -> no rvalid afterwards, starve_cnt=0; both requests re-arbitrate cleanly after rst returns high.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage, one command per cycle.
// Grant and m_* are combinational from requests; read data returns MEM_LAT cycles after the grant, routed by tag.
// Backpressure: a denied requester sees gnt=0 and stall=1 and must hold its request until granted.
module unified_mem_arbiter #(
    parameter int XLEN          = 32,
    parameter int ADDR_W        = 32,
    parameter int MEM_LAT       = 1,
    parameter int DATA_PRIORITY = 1,
    parameter int MAX_STARVE    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [2:0]        d_func3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [XLEN-1:0]   m_wdata,
    output logic [2:0]        m_func3,
    input  logic [XLEN-1:0]   m_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_D    = 2'd2
    } tag_e;

    localparam bit         HI_IS_D    = (DATA_PRIORITY != 0);
    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);
    localparam logic [2:0] FETCH_F3   = 3'b010;

    logic [3:0]      starve_q, starve_d;
    tag_e            tag_q [MEM_LAT];
    tag_e            tag_d [MEM_LAT];
    tag_e            new_tag;
    tag_e            emerge_tag;
    logic [XLEN-1:0] if_rdata_q, d_rdata_q;
    logic            starved;
    logic            lo_req, lo_gnt;

    // Grant selection; reset masks everything so no command leaks out while rst=0.
    always_comb begin
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        starved = (starve_q == STARVE_MAX);
        if (rst) begin
            if (if_req && d_req) begin
                d_gnt  = HI_IS_D ? ~starved : starved;
                if_gnt = ~d_gnt;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_func3 = 3'b000;
        if (if_gnt) begin
            m_en    = 1'b1;
            m_addr  = if_addr;
            m_func3 = FETCH_F3;
        end else if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_func3 = d_func3;
        end
    end

    assign stall_if  = rst & if_req & ~if_gnt;
    assign stall_mem = rst & d_req & ~d_gnt;

    // Starvation tracking applies only to the low-priority port.
    always_comb begin
        lo_req   = HI_IS_D ? if_req : d_req;
        lo_gnt   = HI_IS_D ? if_gnt : d_gnt;
        starve_d = starve_q;
        if (lo_req && lo_gnt) begin
            starve_d = 4'd0;
        end else if (lo_req && !starved) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        if (if_gnt) begin
            new_tag = TAG_IF;
        end else if (d_gnt && !d_we) begin
            new_tag = TAG_D;
        end else begin
            new_tag = TAG_NONE;
        end
        tag_d[0] = new_tag;
        // A flush kills fetch tags already in flight but not the fetch issued alongside it.
        for (int i = 1; i < MEM_LAT; i++) begin
            if (if_flush && tag_q[i-1] == TAG_IF) begin
                tag_d[i] = TAG_NONE;
            end else begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    assign emerge_tag = tag_q[MEM_LAT-1];
    assign if_rvalid  = rst & (emerge_tag == TAG_IF) & ~if_flush;
    assign d_rvalid   = rst & (emerge_tag == TAG_D);
    assign if_rdata   = if_rvalid ? m_rdata : if_rdata_q;
    assign d_rdata    = d_rvalid  ? m_rdata : d_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_q   <= 4'd0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata;
            d_rdata_q  <= d_rdata;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: two arbiters (MEM_LAT=1 and MEM_LAT=3) share stimulus, each backed by its own memory model.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [2:0]  d_func3;

    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, m_en1, m_we1, stall_if1, stall_mem1;
    logic [31:0] if_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
    logic [2:0]  m_func3_1;
    logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, m_en3, m_we3, stall_if3, stall_mem3;
    logic [31:0] if_rdata3, d_rdata3, m_addr3, m_wdata3, m_rdata3;
    logic [2:0]  m_func3_3;

    int total;
    int bad;

    unified_mem_arbiter #(.XLEN(32), .ADDR_W(32), .MEM_LAT(1), .DATA_PRIORITY(1), .MAX_STARVE(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_func3(m_func3_1),
        .m_rdata(m_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1)
    );

    unified_mem_arbiter #(.XLEN(32), .ADDR_W(32), .MEM_LAT(3), .DATA_PRIORITY(1), .MAX_STARVE(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_func3(m_func3_3),
        .m_rdata(m_rdata3), .stall_if(stall_if3), .stall_mem(stall_mem3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word at byte address a starts as 32'h1000_0000 | a.
    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];
    logic [31:0] rd1;
    logic [31:0] rd3 [3];
    assign m_rdata1 = rd1;
    assign m_rdata3 = rd3[2];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 32'h1000_0000 | (i << 2);
            mem3[i] = 32'h1000_0000 | (i << 2);
        end
        rd1 = 32'h0;
        for (int i = 0; i < 3; i++) rd3[i] = 32'h0;
        forever begin
            @(posedge clk);
            rd1    <= (m_en1 && !m_we1) ? mem1[m_addr1[11:2]] : 32'h0;
            rd3[0] <= (m_en3 && !m_we3) ? mem3[m_addr3[11:2]] : 32'h0;
            rd3[1] <= rd3[0];
            rd3[2] <= rd3[1];
            if (m_en1 && m_we1) mem1[m_addr1[11:2]] <= m_wdata1;
            if (m_en3 && m_we3) mem3[m_addr3[11:2]] <= m_wdata3;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 0; if_flush = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_func3 = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle();
        repeat (2) nxt();

        // Reset state: requests present, everything must stay quiet
        if_req = 1; if_addr = 32'h100; d_req = 1; d_addr = 32'h200;
        @(negedge clk);
        chk("rst_gnt", {if_gnt1, d_gnt1, if_gnt3, d_gnt3}, 0);
        chk("rst_men_stall", {m_en1, m_en3, m_we1, stall_if1, stall_mem1, stall_if3, stall_mem3}, 0);
        chk("rst_maddr", m_addr1, 0);
        chk("rst_rdata", {if_rdata1, d_rdata3}, 0);
        chk("rst_rvalid", {if_rvalid1, d_rvalid1, if_rvalid3, d_rvalid3}, 0);
        nxt();
        rst = 1'b1;
        idle();
        nxt();

        // T1: lone fetch at 0x100
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        chk("t1_gnt", {if_gnt1, d_gnt1, stall_if1}, 3'b100);
        chk("t1_maddr", m_addr1, 32'h100);
        chk("t1_mcmd", {m_en1, m_we1, m_func3_1}, 5'b10010);
        nxt();
        idle();
        @(negedge clk);
        chk("t1_rvalid1", if_rvalid1, 1);
        chk("t1_rdata1", if_rdata1, 32'h1000_0100);
        chk("t1_rvalid3_early", if_rvalid3, 0);
        nxt();
        nxt();
        @(negedge clk);
        chk("t1_rvalid3", {if_rvalid3, d_rvalid3}, 2'b10);
        chk("t1_rdata3", if_rdata3, 32'h1000_0100);
        nxt();

        // T2: contention with starvation bound 4
        if_req = 1; if_addr = 32'h104; d_req = 1; d_addr = 32'h200; d_func3 = 3'b010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("t2_gnt1_c%0d", k), {d_gnt1, if_gnt1}, (k == 4) ? 2'b01 : 2'b10);
            chk($sformatf("t2_stall1_c%0d", k), {stall_if1, stall_mem1}, (k == 4) ? 2'b01 : 2'b10);
            chk($sformatf("t2_gnt3_c%0d", k), {d_gnt3, if_gnt3}, (k == 4) ? 2'b01 : 2'b10);
            if (k == 1) chk("t2_drdata1", {d_rvalid1, d_rdata1}, {1'b1, 32'h1000_0200});
            nxt();
        end
        idle();
        repeat (4) nxt();

        // T3: IF, D read, D write back to back on the MEM_LAT=3 instance
        if_req = 1; if_addr = 32'h108;
        @(negedge clk);
        chk("t3_c0_gnt", if_gnt3, 1);
        nxt();
        idle(); d_req = 1; d_addr = 32'h20C; d_func3 = 3'b010;
        @(negedge clk);
        chk("t3_c1_gnt", d_gnt3, 1);
        chk("t3_c1_dut1", {if_rvalid1, if_rdata1}, {1'b1, 32'h1000_0108});
        nxt();
        d_we = 1; d_addr = 32'h300; d_wdata = 32'h55;
        @(negedge clk);
        chk("t3_c2_wr", {d_gnt3, m_en3, m_we3}, 3'b111);
        nxt();
        idle();
        @(negedge clk);
        chk("t3_c3_rv", {if_rvalid3, d_rvalid3}, 2'b10);
        chk("t3_c3_rd", if_rdata3, 32'h1000_0108);
        nxt();
        @(negedge clk);
        chk("t3_c4_rv", {if_rvalid3, d_rvalid3}, 2'b01);
        chk("t3_c4_rd", d_rdata3, 32'h1000_020C);
        nxt();
        @(negedge clk);
        chk("t3_c5_rv", {if_rvalid3, d_rvalid3}, 2'b00);
        chk("t3_c5_hold", if_rdata3, 32'h1000_0108);
        nxt();

        // T4: flush with fetches in flight plus a fetch issued in the flush cycle
        if_req = 1; if_addr = 32'h110;
        nxt();
        if_addr = 32'h114;
        @(negedge clk);
        chk("t4_c1_dut1", {if_rvalid1, if_rdata1}, {1'b1, 32'h1000_0110});
        nxt();
        if_addr = 32'h118; if_flush = 1;
        @(negedge clk);
        chk("t4_c2_gnt", {if_gnt3, if_gnt1}, 2'b11);
        chk("t4_c2_dut1_flushed", if_rvalid1, 0);
        nxt();
        idle();
        @(negedge clk);
        chk("t4_c3_rv3", if_rvalid3, 0);
        chk("t4_c3_dut1", {if_rvalid1, if_rdata1}, {1'b1, 32'h1000_0118});
        nxt();
        @(negedge clk);
        chk("t4_c4_rv3", if_rvalid3, 0);
        nxt();
        @(negedge clk);
        chk("t4_c5_rv3", {if_rvalid3, if_rdata3}, {1'b1, 32'h1000_0118});
        nxt();

        // T5: write then read back
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_func3 = 3'b010;
        @(negedge clk);
        chk("t5_wr_cmd", {d_gnt1, m_en1, m_we1, m_func3_1}, 6'b111010);
        chk("t5_wr_dat", {m_addr1, m_wdata1}, {32'h40, 32'hDEAD_BEEF});
        nxt();
        d_we = 0; d_wdata = 0;
        @(negedge clk);
        chk("t5_rd_cmd", {d_gnt1, m_en1, m_we1}, 3'b110);
        chk("t5_wr_norv", d_rvalid1, 0);
        nxt();
        idle();
        @(negedge clk);
        chk("t5_rd1", {d_rvalid1, d_rdata1}, {1'b1, 32'hDEAD_BEEF});
        chk("t5_rv3_early", d_rvalid3, 0);
        nxt();
        nxt();
        @(negedge clk);
        chk("t5_rd3", {d_rvalid3, d_rdata3}, {1'b1, 32'hDEAD_BEEF});
        nxt();

        // T6: reset with reads in flight and a non-zero starve count
        if_req = 1; if_addr = 32'h84; d_req = 1; d_addr = 32'h80;
        @(negedge clk);
        chk("t6_c0_gnt", {d_gnt1, if_gnt1}, 2'b10);
        nxt();
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_gnt", {d_gnt1, if_gnt1, d_gnt3, if_gnt3, m_en1, m_en3}, 0);
        chk("t6_rst_rv", {d_rvalid1, if_rvalid1, d_rvalid3, if_rvalid3, stall_if1, stall_mem1}, 0);
        nxt();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t6_gnt1_k%0d", k), {d_gnt1, if_gnt1}, (k == 4) ? 2'b01 : 2'b10);
            chk($sformatf("t6_gnt3_k%0d", k), {d_gnt3, if_gnt3}, (k == 4) ? 2'b01 : 2'b10);
            if (k < 3) chk($sformatf("t6_norv3_k%0d", k), d_rvalid3, 0);
            if (k == 0) chk("t6_k0_cleared", {d_rvalid1, d_rdata1, d_rdata3}, 0);
            if (k == 1) chk("t6_k1_newrd", {d_rvalid1, d_rdata1}, {1'b1, 32'h1000_0080});
            nxt();
        end
        idle();
        repeat (5) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
